// File: rtl/mc14500b_program_loader.sv
// rtl/mc14500b_program_loader.sv - buffers and checks a framed program, then replays it into the MC14500B core
module mc14500b_program_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        err_clr,
  output logic        cpu_rst,
  output logic        prog_write,
  output logic [11:0] prog_cmd,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // A one-entry buffer still needs a one-bit index.
  localparam int IDX_W = (ADDR_W < 1) ? 1 : ADDR_W;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_HI, S_RX_LO, S_RX_CSUM, S_ENTER, S_WRITE, S_EXIT, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  hi_q, hi_d;
  logic [7:0]  csum_q, csum_d;
  logic        loaded_q, loaded_d;
  logic        mem_we;
  logic [11:0] mem_q [DEPTH];

  logic        in_ready_q, in_ready_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        prog_write_q, prog_write_d;
  logic [11:0] prog_cmd_q, prog_cmd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic accept;
  assign accept = in_valid && in_ready_q;

  // State, datapath and output registers; reset parks the core in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      hi_q         <= '0;
      csum_q       <= '0;
      loaded_q     <= 1'b0;
      in_ready_q   <= 1'b0;
      cpu_rst_q    <= 1'b1;
      prog_write_q <= 1'b0;
      prog_cmd_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      hi_q         <= hi_d;
      csum_q       <= csum_d;
      loaded_q     <= loaded_d;
      in_ready_q   <= in_ready_d;
      cpu_rst_q    <= cpu_rst_d;
      prog_write_q <= prog_write_d;
      prog_cmd_q   <= prog_cmd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Instruction buffer; contents need no reset since only written words are replayed
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q[IDX_W-1:0]] <= {hi_q, in_data};
  end

  // Next-state: frame parsing, checking and replay sequencing
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    hi_d     = hi_q;
    csum_d   = csum_q;
    loaded_d = loaded_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        if (in_data == 8'd0 || in_data > DEPTH_B) begin
          state_d = S_ERR;
        end else begin
          state_d = S_RX_HI;
          len_d   = in_data;
          csum_d  = in_data;
          idx_d   = '0;
        end
      end
      S_RX_HI: if (accept) begin
        if (in_data[7:4] != 4'd0) begin
          state_d = S_ERR;
        end else begin
          state_d = S_RX_LO;
          hi_d    = in_data[3:0];
          csum_d  = csum_q ^ in_data;
        end
      end
      S_RX_LO: if (accept) begin
        mem_we = 1'b1;
        csum_d = csum_q ^ in_data;
        if (idx_q == len_q - 8'd1) begin
          state_d = S_RX_CSUM;
        end else begin
          state_d = S_RX_HI;
          idx_d   = idx_q + 8'd1;
        end
      end
      S_RX_CSUM: if (accept) begin
        state_d = (in_data == csum_q) ? S_ENTER : S_ERR;
        idx_d   = '0;
      end
      S_ENTER: begin
        state_d = S_WRITE;
        idx_d   = '0;
      end
      S_WRITE: begin
        if (idx_q == len_q - 8'd1) state_d = S_EXIT;
        else idx_d = idx_q + 8'd1;
      end
      S_EXIT: begin
        state_d  = S_IDLE;
        loaded_d = 1'b1;
      end
      S_ERR: if (err_clr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they land registered; buffer read one word ahead
  always_comb begin
    in_ready_d = (state_d == S_IDLE) || (state_d == S_RX_HI) ||
                 (state_d == S_RX_LO) || (state_d == S_RX_CSUM);
    busy_d     = (state_d != S_IDLE) && (state_d != S_ERR);
    err_d      = (state_d == S_ERR);
    done_d     = (state_q == S_EXIT) && (state_d == S_IDLE);
    cpu_rst_d    = !loaded_d;
    prog_write_d = 1'b0;
    prog_cmd_d   = '0;
    case (state_d)
      S_ENTER: begin
        cpu_rst_d    = 1'b1;
        prog_write_d = 1'b1;
      end
      S_WRITE: begin
        cpu_rst_d    = 1'b0;
        prog_write_d = 1'b1;
        prog_cmd_d   = mem_q[idx_d[IDX_W-1:0]];
      end
      S_EXIT: cpu_rst_d = 1'b1;
      default: ;
    endcase
  end

  assign in_ready   = in_ready_q;
  assign cpu_rst    = cpu_rst_q;
  assign prog_write = prog_write_q;
  assign prog_cmd   = prog_cmd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mc14500b_program_loader.sv
// tb/tb_mc14500b_program_loader.sv - randomized self-checking bench for mc14500b_program_loader
module tb_mc14500b_program_loader;

  localparam int DEPTH = 32;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [11:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        err_clr = 1'b0;
  logic        cpu_rst;
  logic        prog_write;
  logic [11:0] prog_cmd;
  logic        busy;
  logic        done;
  logic        err;

  int  chk_cnt = 0;
  int  pass_cnt = 0;
  int  pw_cnt = 0;
  bit  loaded_m = 1'b0;

  mc14500b_program_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .err_clr(err_clr), .cpu_rst(cpu_rst), .prog_write(prog_write), .prog_cmd(prog_cmd),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (prog_write) pw_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired chk=%0d pass=%0d", chk_cnt, pass_cnt);
    $fatal(1);
  end

  // Frame built straight from the format rules: LEN, HI/LO pairs, XOR checksum
  function automatic byte_q_t make_frame(input word_q_t w);
    byte_q_t f;
    logic [7:0] x;
    x = 8'(w.size());
    f.push_back(x);
    foreach (w[i]) begin
      f.push_back({4'h0, w[i][11:8]});
      f.push_back(w[i][7:0]);
      x = x ^ {4'h0, w[i][11:8]} ^ w[i][7:0];
    end
    f.push_back(x);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 64 && !in_ready; i++) @(negedge clk);
    chk_cnt++;
    if ({in_ready, cpu_rst, prog_write} !== {1'b1, ~loaded_m, 1'b0})
      $display("FAIL rx_idle_state got ready/cpu_rst/write=%b%b%b want 1%b0",
               in_ready, cpu_rst, prog_write, ~loaded_m);
    else pass_cnt++;
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_frame(input byte_q_t f, input int gmin, input int gmax);
    foreach (f[i]) send_byte(f[i], $urandom_range(gmax, gmin));
  endtask

  // Expected trace for cycles C1..C(N+3) after checksum acceptance
  task automatic check_replay(input word_q_t w, input string tag);
    int n;
    logic [17:0] exp, got;
    n = w.size();
    for (int c = 1; c <= n + 3; c++) begin
      @(negedge clk);
      if (c == 1)           exp = {1'b1, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0};
      else if (c <= n + 1)  exp = {1'b0, 1'b1, w[c-2],  1'b0, 1'b1, 1'b0, 1'b0};
      else if (c == n + 2)  exp = {1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0};
      else                  exp = {1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0};
      got = {cpu_rst, prog_write, prog_cmd, in_ready, busy, done, err};
      chk_cnt++;
      if (got !== exp)
        $display("FAIL %s replay cycle C%0d got rst/wr/cmd/rdy/busy/done/err=%h want %h",
                 tag, c, got, exp);
      else pass_cnt++;
    end
    loaded_m = 1'b1;
  endtask

  // Entry into ERR right after the offending byte, hold, then err_clr back to IDLE
  task automatic check_err(input string tag);
    logic [5:0] exp, got;
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, 1'b0, ~loaded_m, 1'b0};
    got = {err, in_ready, busy, prog_write, cpu_rst, done};
    chk_cnt++;
    if (got !== exp) $display("FAIL %s err_entry got err/rdy/busy/wr/rst/done=%b want %b", tag, got, exp);
    else pass_cnt++;
    in_valid = 1'b1;
    in_data  = 8'h02;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    got = {err, in_ready, busy, prog_write, cpu_rst, done};
    chk_cnt++;
    if (got !== exp) $display("FAIL %s err_hold got %b want %b", tag, got, exp);
    else pass_cnt++;
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({err, in_ready, busy, cpu_rst} !== {1'b0, 1'b1, 1'b0, ~loaded_m})
      $display("FAIL %s err_clear got err/rdy/busy/rst=%b%b%b%b want 01%b%b", tag,
               err, in_ready, busy, cpu_rst, 1'b0, ~loaded_m);
    else pass_cnt++;
  endtask

  function automatic word_q_t test1_words();
    word_q_t w;
    w.push_back(12'h6FF);
    w.push_back(12'hBFF);
    return w;
  endfunction

  function automatic word_q_t test2_words();
    word_q_t w;
    w = '{12'h6FF, 12'hBFF, 12'hAFF, 12'h800, 12'h801, 12'h200,
          12'h401, 12'h800, 12'h801, 12'h802, 12'hC00};
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({cpu_rst, prog_write, prog_cmd, in_ready, busy, done, err} !== {1'b1, 1'b0, 12'h000, 4'b0000})
      $display("FAIL reset_state got %b%b%h%b%b%b%b want 1 0 000 0000",
               cpu_rst, prog_write, prog_cmd, in_ready, busy, done, err);
    else pass_cnt++;
    rst = 1'b1;
    loaded_m = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({in_ready, cpu_rst, err} !== 3'b110)
      $display("FAIL reset_release got rdy/rst/err=%b%b%b want 110", in_ready, cpu_rst, err);
    else pass_cnt++;
  endtask

  task automatic test_err_clr_ignored();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({err, in_ready, busy} !== 3'b010)
      $display("FAIL err_clr_idle got err/rdy/busy=%b%b%b want 010", err, in_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_header_errors();
    byte_q_t f;
    int pw0;
    pw0 = pw_cnt;
    f = '{8'h00};
    send_frame(f, 0, 0);
    check_err("len_zero");
    f = '{8'(DEPTH + 1)};
    send_frame(f, 0, 0);
    check_err("len_over");
    f = '{8'h02, 8'h1C};
    send_frame(f, 0, 0);
    check_err("hi_nibble");
    f = '{8'h03, 8'h05, 8'h33, {4'($urandom_range(15, 1)), 4'($urandom)}};
    send_frame(f, 0, 1);
    check_err("hi_nibble_rand");
    chk_cnt++;
    if (pw_cnt !== pw0) $display("FAIL header_no_write got %0d write cycles want 0", pw_cnt - pw0);
    else pass_cnt++;
  endtask

  task automatic test_bad_csum_first();
    byte_q_t f;
    int pw0;
    pw0 = pw_cnt;
    f = '{8'h01, 8'h08, 8'h00, 8'h00};
    send_frame(f, 0, 0);
    check_err("csum_first");
    chk_cnt++;
    if (pw_cnt !== pw0) $display("FAIL csum_first_no_write got %0d write cycles want 0", pw_cnt - pw0);
    else pass_cnt++;
    send_frame(make_frame(test1_words()), 0, 0);
    check_replay(test1_words(), "basic_load");
    @(negedge clk);
    chk_cnt++;
    if ({cpu_rst, done, busy} !== 3'b000)
      $display("FAIL post_load got rst/done/busy=%b%b%b want 000", cpu_rst, done, busy);
    else pass_cnt++;
  endtask

  task automatic test_full_program();
    send_frame(make_frame(test2_words()), 3, 3);
    check_replay(test2_words(), "full_program");
  endtask

  task automatic test_bad_csum_loaded();
    byte_q_t f;
    int pw0;
    word_q_t w;
    pw0 = pw_cnt;
    f = '{8'h01, 8'h08, 8'h00, 8'h00};
    send_frame(f, 0, 0);
    check_err("csum_loaded");
    for (int i = 0; i < 3; i++) w.push_back(12'($urandom));
    f = make_frame(w);
    f[f.size()-1] = f[f.size()-1] ^ 8'($urandom_range(255, 1));
    send_frame(f, 0, 2);
    check_err("csum_loaded_rand");
    chk_cnt++;
    if (pw_cnt !== pw0) $display("FAIL csum_loaded_no_write got %0d write cycles want 0", pw_cnt - pw0);
    else pass_cnt++;
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 6; k++) begin
      word_q_t w;
      int n;
      n = (k == 0) ? 1 : (k == 1) ? DEPTH : $urandom_range(DEPTH, 1);
      for (int i = 0; i < n; i++) w.push_back(12'($urandom));
      send_frame(make_frame(w), 0, 2);
      check_replay(w, "random");
    end
  endtask

  task automatic test_back_to_back();
    word_q_t a, b;
    for (int i = 0; i < 4; i++) a.push_back(12'($urandom));
    for (int i = 0; i < 3; i++) b.push_back(12'($urandom));
    send_frame(make_frame(a), 0, 0);
    check_replay(a, "b2b_first");
    send_frame(make_frame(b), 0, 0);
    check_replay(b, "b2b_second");
  endtask

  task automatic test_async_reset();
    word_q_t w;
    w = test2_words();
    send_frame(make_frame(w), 3, 3);
    repeat (6) @(negedge clk);
    chk_cnt++;
    if ({prog_write, prog_cmd} !== {1'b1, w[4]})
      $display("FAIL fifth_write got wr/cmd=%b/%h want 1/%h", prog_write, prog_cmd, w[4]);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if ({prog_write, cpu_rst, busy, in_ready, done, err} !== 6'b010000)
      $display("FAIL async_reset got wr/rst/busy/rdy/done/err=%b%b%b%b%b%b want 010000",
               prog_write, cpu_rst, busy, in_ready, done, err);
    else pass_cnt++;
    loaded_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send_frame(make_frame(test1_words()), 0, 0);
    check_replay(test1_words(), "after_reset");
  endtask

  initial begin
    test_reset();
    test_err_clr_ignored();
    test_header_errors();
    test_bad_csum_first();
    test_full_program();
    test_bad_csum_loaded();
    test_random_frames();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mc14500b_program_loader.md
Name: mc14500b_program_loader

Overview:
Upstream stage of the MC14500B core. It receives a program as a framed byte stream over a valid/ready link, buffers the whole frame, and checks it. Only after the frame passes does it replay the program into the core. The replay drives the core's rst, program_write and program_cmd[11:0] inputs in the core's load protocol: one reset+write cycle, then back-to-back command cycles, then a reset cycle with write low. A frame that fails any check never disturbs the core.

Parameters:
DEPTH, 32, maximum number of 12-bit instructions in the buffer (1..255)
ADDR_W, $clog2(DEPTH), buffer index width

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  asynchronous, active-low reset of this block
in_valid  input  1  byte available on in_data
in_data  input  8  frame byte
in_ready  output  1  byte is accepted when in_valid && in_ready at the rising edge
err_clr  input  1  single-cycle pulse; leaves ERR and returns to IDLE
cpu_rst  output  1  drives the core rst (active-high)
prog_write  output  1  drives the core program_write
prog_cmd  output  12  drives the core program_cmd; {opcode[3:0], operand[7:0]}
busy  output  1  a frame is in progress (receive or replay)
done  output  1  one-cycle pulse after a successful replay
err  output  1  sticky error flag

Behaviour:
- Reset (rst=0, asynchronous) sets outputs to: cpu_rst=1, prog_write=0, prog_cmd=0, in_ready=0, busy=0, done=0, err=0. It also sets state=IDLE and loaded=0. A reset in any state, including mid-replay, takes effect immediately.
- Output registration: every output is registered. The buffer is read ahead so that replay is gap-free.
- cpu_rst outside replay: equals !loaded. Before the first successful load the core is held in reset. After that the core runs.
- Frame format:
  - LEN byte (N)
  - N pairs of bytes: HI, then LO. HI[7:4] must be 0. The word is {HI[3:0], LO}.
  - CSUM byte, equal to the XOR of LEN and all 2N instruction bytes.
- States: IDLE, RX_HI, RX_LO, RX_CSUM, ENTER, WRITE, EXIT, ERR.
- IDLE: in_ready=1. On accepting LEN:
  - N==0 or N>DEPTH goes to ERR.
  - Otherwise store N, init the running XOR, clear the index, go to RX_HI, busy=1.
- RX_HI: in_ready=1.
  - HI[7:4]!=0 goes to ERR.
  - Otherwise latch the nibble and go to RX_LO.
- RX_LO: in_ready=1. Write buf[idx]; if idx==N-1 go to RX_CSUM, else idx++ and go to RX_HI.
- RX_CSUM: in_ready=1.
  - Mismatch goes to ERR.
  - Match goes to ENTER.
- Core state while receiving: untouched (prog_write=0, cpu_rst=!loaded).
- Replay timing, where C0 is the checksum acceptance edge:
  - C1 (ENTER): cpu_rst=1, prog_write=1, prog_cmd=0.
  - C2..C(N+1) (WRITE): cpu_rst=0, prog_write=1, prog_cmd=buf[0..N-1]. One word per cycle, no gaps.
  - C(N+2) (EXIT): cpu_rst=1, prog_write=0, prog_cmd=0.
  - C(N+3) (IDLE): done=1 for this one cycle, busy=0, loaded=1, cpu_rst=0, in_ready=1.
- in_ready is 0 throughout ENTER/WRITE/EXIT, so no byte is consumed during replay.
- ERR:
  - err=1, in_ready=0, busy=0, prog_write=0, cpu_rst=!loaded; a previously loaded program keeps running.
  - Remains in ERR until err_clr, then IDLE with err=0 on the next cycle. The host must resend from LEN.
  - err_clr outside ERR is ignored.
- Gaps in in_valid are legal in any receive state; state holds until a byte is accepted.
- Buffer contents beyond N are don't-care. A new frame overwrites from index 0.

Test Plan:
1. Valid load, loaded=0. Stimulus: 02 06 FF 0B FF 0F. Response: ENTER (cpu_rst=1, write=1); next two cycles prog_cmd=6FF then BFF with write=1; EXIT (cpu_rst=1, write=0); done pulse; cpu_rst=0 afterwards.
2. Full 11-word program. Stimulus: the 11-word program 6FF,BFF,AFF,800,801,200,401,800,801,802,C00, with in_valid dropping for 3 cycles between bytes. Response: identical gap-free 11-cycle WRITE burst, and in_ready=0 for all 13 replay cycles.
3. Bad checksum on the first load. Stimulus: 01 08 00 00. Response: err=1; prog_write never asserted; cpu_rst stays 1. Then err_clr plus a valid frame gives a normal load.
4. Bad checksum after a successful load. Stimulus: a valid load, then 01 08 00 00. Response: err=1, cpu_rst stays 0, prog_write stays 0.
5. Header and nibble errors. Stimulus: LEN=00, LEN=21 (DEPTH+1), and a HI byte of 1C. Response: in each case ERR on that byte's acceptance edge, with in_ready=0 on the following cycle.
6. Async reset mid-replay. Stimulus: rst low during the 5th WRITE cycle of test 2. Response: immediately prog_write=0, cpu_rst=1, busy=0. After release, test 1 passes unchanged.
